// File: rtl/axi_pkg.sv
// Shared AXI constants and the read-arbiter FSM state encoding.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational round-robin pick; on a tie the slot that did not win last time gets it.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read channel between the instruction cache (slot 0) and the data cache
// (slot 1): round-robin grant, one outstanding burst, grant held until the last beat.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*ADDR_WIDTH-1:0] s_araddr,
  input  logic [15:0]             s_arlen,
  input  logic [5:0]              s_arsize,
  input  logic [1:0]              s_arvalid,
  output logic [1:0]              s_arready,
  output logic [31:0]             s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic [1:0]              s_rvalid,
  input  logic [1:0]              s_rready,
  output logic [ID_WIDTH-1:0]     arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic                    err
);

  arb_state_t state, state_next;
  logic       grant, last_grant;
  logic [7:0] beat_cnt;
  logic [1:0] pick;
  logic       pick_idx;
  logic       beat;
  logic       proto_err;

  rr_arbiter2 u_rr (
    .req        (s_arvalid),
    .last_grant (last_grant),
    .gnt        (pick)
  );

  assign pick_idx = pick[1];
  assign arburst  = AXI_BURST_INCR;
  assign beat     = rvalid & rready;

  assign proto_err = (rlast && (beat_cnt != arlen)) ||
                     (!rlast && (beat_cnt == arlen)) ||
                     (rid != arid) ||
                     (rresp != AXI_RESP_OKAY);

  // NOTE: reset is sampled on the clock edge only, so it sits inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next = state;
    s_arready  = 2'b00;
    s_rvalid   = 2'b00;
    rready     = 1'b0;
    s_rdata    = '0;
    s_rresp    = '0;
    s_rlast    = 1'b0;
    case (state)
      IDLE: begin
        s_arready = pick;
        if (|pick) state_next = ADDR;
      end
      ADDR: begin
        if (arready) state_next = DATA;
      end
      DATA: begin
        s_rvalid[grant] = rvalid;
        rready          = s_rready[grant];
        s_rdata         = rdata;
        s_rresp         = rresp;
        s_rlast         = rlast;
        if (rvalid && s_rready[grant] && rlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      arvalid    <= 1'b0;
      arid       <= '0;
      araddr     <= '0;
      arlen      <= '0;
      arsize     <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|pick) begin
            grant   <= pick_idx;
            arid    <= {{(ID_WIDTH-1){1'b0}}, pick_idx};
            araddr  <= pick_idx ? s_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_araddr[ADDR_WIDTH-1:0];
            arlen   <= pick_idx ? s_arlen[15:8] : s_arlen[7:0];
            arsize  <= pick_idx ? s_arsize[5:3] : s_arsize[2:0];
            arvalid <= 1'b1;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid  <= 1'b0;
            beat_cnt <= '0;
          end
        end
        DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
            // Errors are only recorded; the burst still ends on rlast.
            if (proto_err) err <= 1'b1;
            if (rlast)     last_grant <= grant;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: a cycle table for the basic handshakes plus
// hand-written burst sequences for arbitration, AR stalls, protocol errors and mid-burst reset.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr0, addr1;
  logic [7:0]  len0, len1;
  logic [63:0] s_araddr;
  logic [15:0] s_arlen;
  logic [5:0]  s_arsize;
  logic [1:0]  s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [1:0]  s_rvalid, s_rready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, err;

  int checks   = 0;
  int failures = 0;

  assign s_araddr = {addr1, addr0};
  assign s_arlen  = {len1, len0};
  assign s_arsize = 6'b010_010;

  always #5 clk = ~clk;

  axi_read_arbiter #(.ADDR_WIDTH(32), .ID_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .err(err)
  );

  typedef struct {
    logic [1:0] req;
    logic       ar_rdy;
    logic       r_vld;
    logic       r_last;
    logic [1:0] srr;
    logic [3:0] r_id;
    logic [1:0] e_sar;
    logic       e_arv;
    logic [3:0] e_arid;
    logic [1:0] e_srv;
    logic       e_rr;
    logic       e_err;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    s_arvalid = 2'b00; s_rready = 2'b00; arready = 1'b0;
    rvalid = 1'b0; rlast = 1'b0; rid = '0; rresp = '0; rdata = '0;
    repeat (2) next_cycle();
    rst = 1'b1;
  endtask

  // Drives one burst from the IDLE cycle to the cycle after its last beat.
  task automatic run_burst(input logic [1:0] req, input int slot, input int ar_wait,
                           input int last_idx, input int abort_at, input string tag);
    logic [1:0]  onehot;
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;
    onehot   = (slot == 1) ? 2'b10 : 2'b01;
    exp_addr = (slot == 1) ? addr1 : addr0;
    exp_len  = (slot == 1) ? len1 : len0;
    s_arvalid = req; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk);
    check({tag, " s_arready"}, 32'(s_arready), 32'(onehot));
    check({tag, " arvalid idle"}, 32'(arvalid), 32'd0);
    next_cycle();
    s_arvalid = s_arvalid & ~onehot;
    if (slot == 1) addr1 = ~addr1; else addr0 = ~addr0;
    for (int w = 0; w < ar_wait; w++) begin
      @(negedge clk);
      check({tag, " arvalid stall"}, 32'(arvalid), 32'd1);
      check({tag, " araddr stall"}, araddr, exp_addr);
      check({tag, " arlen stall"}, 32'(arlen), 32'(exp_len));
      next_cycle();
    end
    arready = 1'b1;
    @(negedge clk);
    check({tag, " arvalid"}, 32'(arvalid), 32'd1);
    check({tag, " arid"}, 32'(arid), 32'(slot));
    check({tag, " araddr"}, araddr, exp_addr);
    check({tag, " arburst"}, 32'(arburst), 32'd1);
    next_cycle();
    arready = 1'b0;
    for (int i = 0; i <= last_idx; i++) begin
      rvalid = 1'b1; rid = 4'(slot); rresp = 2'b00; rlast = (i == last_idx);
      rdata = 32'hC000_0000 | 32'(slot << 8) | 32'(i);
      s_rready = 2'b11;
      if (i == abort_at) rst = 1'b0;
      @(negedge clk);
      check({tag, " s_rvalid"}, 32'(s_rvalid), 32'(onehot));
      check({tag, " s_rdata"}, s_rdata, rdata);
      check({tag, " s_rlast"}, 32'(s_rlast), 32'(rlast));
      check({tag, " rready"}, 32'(rready), 32'd1);
      next_cycle();
      if (i == abort_at) break;
    end
    rst = 1'b1; rvalid = 1'b0; rlast = 1'b0; s_rready = 2'b00;
    if (slot == 1) addr1 = exp_addr; else addr0 = exp_addr;
  endtask

  initial begin
    vecs[0]  = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 2'b00, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 2'b01, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 2'b00, 1'b1, 4'd0, 2'b00, 1'b0, 1'b0};
    vecs[3]  = '{2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 2'b00, 1'b1, 4'd0, 2'b00, 1'b0, 1'b0};
    vecs[4]  = '{2'b10, 1'b0, 1'b1, 1'b0, 2'b01, 4'd0, 2'b00, 1'b0, 4'd0, 2'b01, 1'b1, 1'b0};
    vecs[5]  = '{2'b10, 1'b0, 1'b1, 1'b1, 2'b11, 4'd0, 2'b00, 1'b0, 4'd0, 2'b01, 1'b1, 1'b0};
    vecs[6]  = '{2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 2'b10, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0};
    vecs[7]  = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b11, 4'd1, 2'b00, 1'b1, 4'd1, 2'b00, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 4'd1, 2'b00, 1'b0, 4'd1, 2'b10, 1'b0, 1'b0};
    vecs[9]  = '{2'b00, 1'b0, 1'b1, 1'b1, 2'b10, 4'd1, 2'b00, 1'b0, 4'd1, 2'b10, 1'b1, 1'b0};
    vecs[10] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 4'd0, 2'b00, 1'b0, 4'd1, 2'b00, 1'b0, 1'b0};

    addr0 = 32'h0000_1000; len0 = 8'd1;
    addr1 = 32'h0000_2000; len1 = 8'd0;
    do_reset();

    @(negedge clk);
    check("reset araddr", araddr, 32'd0);
    check("reset arlen", 32'(arlen), 32'd0);
    check("reset arsize", 32'(arsize), 32'd0);
    next_cycle();

    for (int i = 0; i < 11; i++) begin
      s_arvalid = vecs[i].req; arready = vecs[i].ar_rdy;
      rvalid = vecs[i].r_vld; rlast = vecs[i].r_last; s_rready = vecs[i].srr;
      rid = vecs[i].r_id; rresp = 2'b00; rdata = 32'h5A00_0000 + 32'(i);
      @(negedge clk);
      check($sformatf("vec%0d s_arready", i), 32'(s_arready), 32'(vecs[i].e_sar));
      check($sformatf("vec%0d arvalid", i), 32'(arvalid), 32'(vecs[i].e_arv));
      check($sformatf("vec%0d arid", i), 32'(arid), 32'(vecs[i].e_arid));
      check($sformatf("vec%0d s_rvalid", i), 32'(s_rvalid), 32'(vecs[i].e_srv));
      check($sformatf("vec%0d rready", i), 32'(rready), 32'(vecs[i].e_rr));
      check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].e_err));
      check($sformatf("vec%0d s_rdata", i), s_rdata,
            (vecs[i].e_srv != 2'b00) ? rdata : 32'd0);
      next_cycle();
    end

    // Single requester, 16-beat refill.
    do_reset();
    addr0 = 32'h1FC0_0000; len0 = 8'd15;
    run_burst(2'b01, 0, 0, 15, -1, "t1");
    rvalid = 1'b1; s_rready = 2'b11;
    @(negedge clk);
    check("t1 idle s_rvalid", 32'(s_rvalid), 32'd0);
    check("t1 idle rready", 32'(rready), 32'd0);
    check("t1 err", 32'(err), 32'd0);
    next_cycle();
    rvalid = 1'b0; s_rready = 2'b00;

    // Simultaneous requests after reset, then continuous contention.
    do_reset();
    addr0 = 32'h0000_1000; len0 = 8'd7;
    addr1 = 32'h8000_0040; len1 = 8'd3;
    run_burst(2'b11, 0, 0, 7, -1, "t2a");
    run_burst(2'b10, 1, 0, 3, -1, "t2b");
    for (int k = 0; k < 4; k++)
      run_burst(2'b11, k % 2, 0, (k % 2 == 1) ? 3 : 7, -1, $sformatf("t3_%0d", k));
    s_arvalid = 2'b00;

    // AR channel stalled for 5 cycles.
    len0 = 8'd3;
    run_burst(2'b01, 0, 5, 3, -1, "t4");
    @(negedge clk);
    check("t4 err", 32'(err), 32'd0);
    next_cycle();

    // Early rlast sets the sticky error; the following burst still completes.
    run_burst(2'b01, 0, 0, 2, -1, "t5a");
    @(negedge clk);
    check("t5 err set", 32'(err), 32'd1);
    next_cycle();
    run_burst(2'b01, 0, 0, 3, -1, "t5b");
    @(negedge clk);
    check("t5 err sticky", 32'(err), 32'd1);
    next_cycle();

    // Reset asserted during the fifth beat of a 16-beat burst.
    len0 = 8'd15;
    run_burst(2'b01, 0, 0, 15, 4, "t6");
    rvalid = 1'b1; s_rready = 2'b11;
    @(negedge clk);
    check("t6 arvalid", 32'(arvalid), 32'd0);
    check("t6 rready", 32'(rready), 32'd0);
    check("t6 s_rvalid", 32'(s_rvalid), 32'd0);
    check("t6 err", 32'(err), 32'd0);
    next_cycle();
    rvalid = 1'b0; s_rready = 2'b00;
    len0 = 8'd1;
    run_burst(2'b11, 0, 0, 1, -1, "t6b");
    s_arvalid = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
